// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/add ops, shift-add MUL and
// restoring unsigned DIV, with valid/ready on both the operand and result sides.
module alu_mc #(
   parameter int WIDTH    = 32,
   parameter bit MUL_ITER = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       flags,
   output logic             div0,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV = 3'b011,
      OP_AND = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_NOT = 3'b111
   } op_e;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   state_e           state;
   logic             div_q;
   logic             div0_pend_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] acc_q;

   op_e              op_in;
   logic             accept;
   logic             iter_op;
   logic [WIDTH-1:0] single_res;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] x_nxt;
   logic [WIDTH-1:0] y_nxt;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] iter_res;

   function automatic logic [1:0] flags_of(input logic [WIDTH-1:0] v);
      return {v == '0, v[WIDTH-1]};
   endfunction

   assign op_in    = op_e'(op);
   assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign iter_op  = (op_in == OP_DIV) || ((op_in == OP_MUL) && MUL_ITER);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      single_res = '0;
      unique case (op_in)
         OP_ADD:  single_res = a + b;
         OP_SUB:  single_res = a - b;
         OP_MUL:  single_res = a * b;
         OP_AND:  single_res = a & b;
         OP_OR:   single_res = a | b;
         OP_XOR:  single_res = a ^ b;
         OP_NOT:  single_res = ~a;
         default: single_res = '0;
      endcase
   end

   // One iteration step. DIV: x_q shifts the dividend out and the quotient in,
   // acc_q is the partial remainder. MUL: x_q is the shifted multiplicand,
   // y_q the multiplier consumed LSB first, acc_q the running product.
   always_comb begin
      rem_sh  = {acc_q, x_q[WIDTH-1]};
      rem_ge  = rem_sh >= {1'b0, y_q};
      x_nxt   = x_q;
      y_nxt   = y_q;
      acc_nxt = acc_q;
      if (div_q) begin
         acc_nxt = rem_ge ? (rem_sh[WIDTH-1:0] - y_q) : rem_sh[WIDTH-1:0];
         x_nxt   = {x_q[WIDTH-2:0], rem_ge};
      end else begin
         acc_nxt = acc_q + (y_q[0] ? x_q : '0);
         x_nxt   = x_q << 1;
         y_nxt   = y_q >> 1;
      end
      iter_res = div_q ? x_nxt : acc_nxt;
   end

   // Divide by zero needs no special case: every compare succeeds, so the
   // quotient fills with ones after the full WIDTH steps.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         out_valid   <= 1'b0;
         result      <= '0;
         flags       <= '0;
         div0        <= 1'b0;
         busy        <= 1'b0;
         cnt_q       <= '0;
         div_q       <= 1'b0;
         div0_pend_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         acc_q       <= '0;
      end else if (accept) begin
         if (iter_op) begin
            state       <= S_BUSY;
            busy        <= 1'b1;
            out_valid   <= 1'b0;
            cnt_q       <= '0;
            div_q       <= (op_in == OP_DIV);
            div0_pend_q <= (op_in == OP_DIV) && (b == '0);
            x_q         <= a;
            y_q         <= b;
            acc_q       <= '0;
         end else begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= single_res;
            flags     <= flags_of(single_res);
            div0      <= 1'b0;
         end
      end else begin
         unique case (state)
            S_BUSY: begin
               x_q   <= x_nxt;
               y_q   <= y_nxt;
               acc_q <= acc_nxt;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  result    <= iter_res;
                  flags     <= flags_of(iter_res);
                  div0      <= div0_pend_q;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
